triple_buf_arbiter: RTL
=======================

TRIPLE_BUF_ARBITER -- requirements
Module: triple_buf_arbiter

Interface
REQ-001 Parameter FRAME_WORDS, default 16384: words per bank; 3*FRAME_WORDS SHALL be <= 65536.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_valid  input  1  writer presents a word.
REQ-005 wr_data  input  16  write word.
REQ-006 wr_last  input  1  qualifies wr_valid; marks the final word of a frame.
REQ-007 wr_ready  output  1  write word accepted this cycle.
REQ-008 rd_req  input  1  reader requests next word.
REQ-009 rd_ready  output  1  read request accepted this cycle.
REQ-010 rd_frame_start  input  1  one-cycle pulse; reader begins a new frame.
REQ-011 rd_valid  output  1  one-cycle pulse; rd_data holds a returned word.
REQ-012 rd_data  output  16  returned word.
REQ-013 ctl_ready  input  1  SRAM controller idle.
REQ-014 ctl_start_n  output  1  active-low access start to the controller.
REQ-015 ctl_rw  output  1  1 = read, 0 = write.
REQ-016 ctl_addr  output  16  access address.
REQ-017 ctl_wdata  output  16  write data.
REQ-018 ctl_rdata  input  16  controller read data.
REQ-019 wr_bank, rd_bank  output  2 each  current writer and reader bank index (0..2).
REQ-020 drop_count  output  8  frames discarded unread (see Configuration).

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE and WAIT: IDLE->ISSUE on acceptance, ISSUE->WAIT unconditionally, WAIT->IDLE on the first cycle ctl_ready=1 after at least one cycle of ctl_ready=0.
REQ-022 Acceptance SHALL occur only in IDLE with ctl_ready=1; wr_ready and rd_ready are combinational, never both high.
REQ-023 When wr_valid and rd_req are both pending, grant SHALL alternate, starting with read after reset; a lone requester SHALL always be granted.
REQ-024 On acceptance, ctl_addr, ctl_rw and ctl_wdata SHALL be registered; ctl_start_n SHALL be 0 for exactly the ISSUE cycle and 1 otherwise.
REQ-025 Address SHALL be bank*FRAME_WORDS + port word counter, computed in 16 bits.
REQ-026 On the WAIT exit cycle of a read, ctl_rdata SHALL be registered into rd_data, and rd_valid SHALL be 1 for the following cycle; rd_valid SHALL occur 4 cycles after rd_ready with the paired controller.
REQ-027 Word counters SHALL increment per accepted word and wrap FRAME_WORDS-1 -> 0 within the same bank.
REQ-028 An accepted write with wr_last=1 SHALL zero the write counter, swap wr_bank with the spare bank and set fresh=1.
REQ-029 On rd_frame_start with fresh=1, the block SHALL swap rd_bank with the spare bank and clear fresh; with fresh=0, banks SHALL be unchanged. In both cases the read counter SHALL be zeroed.
REQ-030 If a write swap and rd_frame_start occur in the same cycle, the write swap SHALL be applied first, so the reader receives the just-completed frame.
REQ-031 A bank swap SHALL affect only accesses accepted afterwards; an in-flight access SHALL complete at its latched address.
REQ-032 wr_bank, rd_bank and the spare bank SHALL always be distinct.

Reset
REQ-033 Reset SHALL force state IDLE, ctl_start_n=1, ctl_rw=1, ctl_addr=0, ctl_wdata=0, rd_valid=0, rd_data=0, counters 0, wr_bank=0, rd_bank=1, spare=2, fresh=0, drop_count=0.
REQ-034 Reset mid-access SHALL abort the access with no rd_valid; the controller completes its own cycle independently.

Configuration
REQ-035 With TRIPLE_BUF_ARBITER_STATS_EN defined, drop_count SHALL increment, saturating at 255, on each write swap occurring while fresh=1.
REQ-036 Without TRIPLE_BUF_ARBITER_STATS_EN, drop_count SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-037 After reset, rd_req=1 alone -> ctl_start_n low 1 cycle, ctl_rw=1, ctl_addr=0x4000 (bank 1), rd_valid 4 cycles after rd_ready, rd_data=ctl_rdata.
REQ-038 Writer streams 3 words at bank 0, last word with wr_last -> ctl_addr 0x0000..0x0002, then wr_bank=2, fresh=1.
REQ-039 Writer and reader both continuously pending -> grants strictly alternate R,W,R,W with one access every 4 cycles.
REQ-040 Write swap and rd_frame_start in the same cycle from reset -> wr_bank=2, rd_bank=0, and the next read address is 0x0000.
REQ-041 Two frames completed with no rd_frame_start, STATS_EN defined -> drop_count=1; after 300 such frames -> 255.
REQ-042 reset asserted in WAIT of a read -> no rd_valid, all outputs at reset values, next access issues normally.

Source files
------------

// File: rtl/triple_buf_arbiter.sv
// Triple-buffered frame arbiter: one SRAM controller shared between a frame writer and a frame reader.
// Optional drop statistics are enabled with the TRIPLE_BUF_ARBITER_STATS_EN macro.
module triple_buf_arbiter #(
    parameter int FRAME_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    input  logic        rd_req,
    output logic        rd_ready,
    input  logic        rd_frame_start,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    input  logic        ctl_ready,
    output logic        ctl_start_n,
    output logic        ctl_rw,
    output logic [15:0] ctl_addr,
    output logic [15:0] ctl_wdata,
    input  logic [15:0] ctl_rdata,
    output logic [1:0]  wr_bank,
    output logic [1:0]  rd_bank,
    output logic [7:0]  drop_count
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ISSUE = 2'd1;
    localparam logic [1:0]  S_WAIT  = 2'd2;
    localparam logic [15:0] FW      = 16'(FRAME_WORDS);
    localparam logic [15:0] LAST_W  = 16'(FRAME_WORDS - 1);

    logic [1:0]  r_state;
    logic        r_seen_busy;
    logic        r_prio_wr;
    logic        r_start_n;
    logic        r_rw;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rd_data;
    logic        r_rd_valid;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;
    logic [1:0]  r_wr_bank;
    logic [1:0]  r_rd_bank;
    logic [1:0]  r_spare;
    logic        r_fresh;

    logic        w_idle_ok;
    logic        w_wr_grant;
    logic        w_rd_grant;
    logic        w_wr_swap;
    logic [1:0]  w_sel_bank;
    logic [15:0] w_sel_cnt;
    logic [15:0] w_addr;
    logic [1:0]  w_wb_n;
    logic [1:0]  w_rb_n;
    logic [1:0]  w_sp_n;
    logic        w_fr_n;

    function automatic logic [15:0] f_next_cnt(input logic [15:0] cnt);
        return (cnt == LAST_W) ? 16'd0 : cnt + 16'd1;
    endfunction

    // When both ports are pending the port that was not served last wins.
    assign w_idle_ok  = (r_state == S_IDLE) && ctl_ready;
    assign w_rd_grant = w_idle_ok && rd_req && (!wr_valid || !r_prio_wr);
    assign w_wr_grant = w_idle_ok && wr_valid && (!rd_req || r_prio_wr);
    assign w_wr_swap  = w_wr_grant && wr_last;
    assign wr_ready   = w_wr_grant;
    assign rd_ready   = w_rd_grant;

    assign w_sel_bank = w_wr_grant ? r_wr_bank : r_rd_bank;
    assign w_sel_cnt  = w_wr_grant ? r_wr_cnt : r_rd_cnt;
    assign w_addr     = ({14'd0, w_sel_bank} * FW) + w_sel_cnt;

    // Write swap is resolved first so a same-cycle frame start picks up the frame just finished.
    always_comb begin
        w_wb_n = r_wr_bank;
        w_rb_n = r_rd_bank;
        w_sp_n = r_spare;
        w_fr_n = r_fresh;
        if (w_wr_swap) begin
            w_wb_n = r_spare;
            w_sp_n = r_wr_bank;
            w_fr_n = 1'b1;
        end
        if (rd_frame_start && w_fr_n) begin
            w_rb_n = w_sp_n;
            w_sp_n = r_rd_bank;
            w_fr_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_seen_busy <= 1'b0;
            r_prio_wr   <= 1'b0;
            r_start_n   <= 1'b1;
            r_rw        <= 1'b1;
            r_addr      <= 16'd0;
            r_wdata     <= 16'd0;
            r_rd_data   <= 16'd0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_start_n  <= 1'b1;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_grant || w_wr_grant) begin
                        r_state   <= S_ISSUE;
                        r_start_n <= 1'b0;
                        r_rw      <= w_rd_grant;
                        r_addr    <= w_addr;
                        r_wdata   <= wr_data;
                        r_prio_wr <= w_rd_grant;
                    end
                end
                S_ISSUE: begin
                    r_state     <= S_WAIT;
                    r_seen_busy <= 1'b0;
                end
                S_WAIT: begin
                    if (!ctl_ready) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_state <= S_IDLE;
                        if (r_rw) begin
                            r_rd_data  <= ctl_rdata;
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_cnt  <= 16'd0;
            r_rd_cnt  <= 16'd0;
            r_wr_bank <= 2'd0;
            r_rd_bank <= 2'd1;
            r_spare   <= 2'd2;
            r_fresh   <= 1'b0;
        end else begin
            r_wr_bank <= w_wb_n;
            r_rd_bank <= w_rb_n;
            r_spare   <= w_sp_n;
            r_fresh   <= w_fr_n;
            if (w_wr_swap)
                r_wr_cnt <= 16'd0;
            else if (w_wr_grant)
                r_wr_cnt <= f_next_cnt(r_wr_cnt);
            if (rd_frame_start)
                r_rd_cnt <= 16'd0;
            else if (w_rd_grant)
                r_rd_cnt <= f_next_cnt(r_rd_cnt);
        end
    end

`ifdef TRIPLE_BUF_ARBITER_STATS_EN
    logic [7:0] r_drop;

    // A write swap while the previous frame is still unread discards that frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop <= 8'd0;
        else if (w_wr_swap && r_fresh && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;
    end

    assign drop_count = r_drop;
`else
    assign drop_count = 8'd0;
`endif

    assign ctl_start_n = r_start_n;
    assign ctl_rw      = r_rw;
    assign ctl_addr    = r_addr;
    assign ctl_wdata   = r_wdata;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign wr_bank     = r_wr_bank;
    assign rd_bank     = r_rd_bank;

endmodule
